key_frame_loader: RTL and testbench
===================================

Name: key_frame_loader

Overview:
- Sequential key-delivery stage that sits directly upstream of the obfuscated c432 netlist.
- Receives a bit-serial key frame over a valid/ready handshake: KEY_W key bits followed by one even-parity bit.
- Parity-checks the frame, then commits it atomically to a parallel key bus that drives the netlist's key inputs (key_out[i] drives s_i).
- Holds a safe default key until a valid frame commits; optionally locks after the first good load.

Parameters:
- KEY_W, 12, number of key bits (one per key input s_0..s_{KEY_W-1}).
- DEFAULT_KEY, 12'h000, key_out value after reset and until the first good commit.
- LOCK_ONCE, 1, 1 = block enters LOCKED after the first good commit and ignores further loads until reset; 0 = reloads allowed.
- TIMEOUT, 16, maximum consecutive idle cycles in SHIFT (key_ready=1, key_valid=0) before the frame is aborted; counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- key_bit  input  1  serial key data, LSB (s_0) first; parity bit last.
- key_valid  input  1  key_bit is valid this cycle.
- key_ready  output  1  loader accepts key_bit this cycle; a beat transfers when key_valid & key_ready.
- key_out  output  KEY_W  committed key; bit i drives s_i.
- key_loaded  output  1  a good frame has committed since reset.
- key_err  output  1  last frame failed parity or timed out.
- busy  output  1  state is SHIFT or CHECK.

Behaviour:
- Reset (async, rst=1): key_out=DEFAULT_KEY, key_loaded=0, key_err=0, key_ready=0, busy=0. The shadow register, bit counter and timeout counter clear; state=IDLE. Reset mid-frame discards the partial frame; there is no output glitch beyond the reset values.
- States: IDLE, SHIFT, CHECK, LOCKED.
- IDLE: key_ready=0. If load_start=1, go to SHIFT, clear the shadow, bit_cnt and to_cnt, and clear key_err.
- SHIFT: key_ready=1, busy=1.
  - On each transfer with bit_cnt<KEY_W: shadow[bit_cnt]<=key_bit, bit_cnt++, to_cnt<=0.
  - On the transfer with bit_cnt==KEY_W: the beat is the parity bit; latch it into pbit and go to CHECK. key_ready drops in the following cycle.
  - Cycle with key_ready=1 and key_valid=0: to_cnt++. When to_cnt reaches TIMEOUT, set key_err=1 and go to IDLE; key_out is unchanged.
  - load_start is ignored while in SHIFT.
- CHECK (one cycle): key_ready=0, busy=1.
  - If ^shadow ^ pbit == 0, the frame is good: key_out<=shadow, key_loaded<=1, key_err stays 0. Next state is LOCKED if LOCK_ONCE=1, else IDLE.
  - Otherwise key_err<=1, key_out unchanged, next state is IDLE.
- Latency: the new key_out is visible one clock after the edge that accepts the parity beat. All KEY_W bits change in the same edge; there is never a partial key on key_out.
- LOCKED: key_ready=0, busy=0. load_start, key_valid and key_bit are ignored. Only rst exits this state.
- key_loaded is sticky until reset. A later failed frame sets key_err but keeps the previous key_out and leaves key_loaded=1.
- key_valid with key_ready=0 is not a transfer; the data is dropped and the bench must not count it.
- Back-to-back beats (key_valid held high) complete a frame in KEY_W+1 cycles in SHIFT, plus one CHECK cycle.

Test Plan:
- Good load: rst, then load_start, then 13 back-to-back beats carrying 0xA5C LSB-first followed by parity 0 -> key_out=12'hA5C one clock after the 13th beat, key_loaded=1, key_err=0, and the block ends in LOCKED (key_ready=0).
- Bad parity: same frame with parity bit 1 -> key_err=1, key_out stays 12'h000, key_loaded=0, state IDLE.
- Timeout: load_start, 5 beats, then key_valid=0 for 16 cycles -> key_err=1 on the 16th idle cycle, key_ready=0 afterwards, key_out unchanged. A following good frame of 0x3F0 (parity 0) commits 12'h3F0 and clears key_err at load_start.
- Lock: with LOCK_ONCE=1, after committing 0xA5C, assert load_start and stream 0x001 (parity 1) -> no key_ready, key_out stays 12'hA5C. With LOCK_ONCE=0, the same stimulus gives key_out=12'h001.
- Stalled handshake: 0xA5C sent with key_valid toggling every other cycle (idle gaps of 1 < TIMEOUT) -> commit is identical to back-to-back, and extra key_valid pulses in IDLE/CHECK are ignored.
- Reset mid-frame: assert rst asynchronously after 7 beats -> key_out=12'h000, key_loaded=0, busy=0 immediately. A fresh full frame afterwards loads correctly.

Source files
------------

// File: rtl/key_frame_loader_if.sv
// Key-delivery handshake and committed-key bus between a frame source and the loader.
interface key_frame_loader_if #(
  parameter int KEY_W = 12
);
  logic             load_start;
  logic             key_bit;
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_loaded;
  logic             key_err;
  logic             busy;

  modport master (
    output load_start, key_bit, key_valid,
    input  key_ready, key_out, key_loaded, key_err, busy
  );

  modport slave (
    input  load_start, key_bit, key_valid,
    output key_ready, key_out, key_loaded, key_err, busy
  );
endinterface

// File: rtl/key_frame_loader.sv
// Bit-serial key frame (KEY_W bits LSB-first + even parity) over valid/ready,
// parity-checked and committed atomically to key_out; optional lock after first good load.
module key_frame_loader #(
  parameter int               KEY_W       = 12,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = '0,
  parameter bit               LOCK_ONCE   = 1'b1,
  parameter int               TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  key_frame_loader_if.slave kif
);
  localparam int BW = $clog2(KEY_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [BW-1:0] PAR_IDX  = BW'(KEY_W);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOCKED} state_t;

  state_t           state_q;
  logic [KEY_W-1:0] shadow_q;
  logic [KEY_W-1:0] key_out_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [TW-1:0]    to_cnt_q;
  logic [TW-1:0]    to_cnt_d;
  logic             pbit_q;
  logic             key_loaded_q;
  logic             key_err_q;
  logic             key_ready_q;
  logic             busy_q;
  logic             frame_ok;

  assign to_cnt_d = to_cnt_q + 1'b1;
  assign frame_ok = ~(^shadow_q ^ pbit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      key_out_q    <= DEFAULT_KEY;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      pbit_q       <= 1'b0;
      key_loaded_q <= 1'b0;
      key_err_q    <= 1'b0;
      key_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (kif.load_start) begin
            state_q     <= SHIFT;
            shadow_q    <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            key_err_q   <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SHIFT: begin
          // key_ready_q is always 1 here, so key_valid alone marks a transfer
          if (kif.key_valid) begin
            to_cnt_q <= '0;
            if (bit_cnt_q == PAR_IDX) begin
              pbit_q      <= kif.key_bit;
              key_ready_q <= 1'b0;
              state_q     <= CHECK;
            end else begin
              shadow_q[bit_cnt_q[IW-1:0]] <= kif.key_bit;
              bit_cnt_q                   <= bit_cnt_q + 1'b1;
            end
          end else if (to_cnt_d == TO_LIMIT) begin
            key_err_q   <= 1'b1;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (frame_ok) begin
            key_out_q    <= shadow_q;
            key_loaded_q <= 1'b1;
            state_q      <= LOCK_ONCE ? LOCKED : IDLE;
          end else begin
            key_err_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        LOCKED: state_q <= LOCKED;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kif.key_ready  = key_ready_q;
  assign kif.key_out    = key_out_q;
  assign kif.key_loaded = key_loaded_q;
  assign kif.key_err    = key_err_q;
  assign kif.busy       = busy_q;
endmodule

// File: tb/tb_key_frame_loader.sv
// Scoreboard bench: two loaders (LOCK_ONCE=1 and 0) share stimulus; a frame-level model predicts each frame's outcome.
module tb_key_frame_loader;
  logic clk;
  logic rst;

  key_frame_loader_if #(.KEY_W(12)) kif0 ();
  key_frame_loader_if #(.KEY_W(12)) kif1 ();

  assign kif1.load_start = kif0.load_start;
  assign kif1.key_bit    = kif0.key_bit;
  assign kif1.key_valid  = kif0.key_valid;

  key_frame_loader #(.KEY_W(12), .DEFAULT_KEY(12'h000), .LOCK_ONCE(1'b1), .TIMEOUT(16)) dut_lk (
    .clk(clk), .rst(rst), .kif(kif0.slave));
  key_frame_loader #(.KEY_W(12), .DEFAULT_KEY(12'h000), .LOCK_ONCE(1'b0), .TIMEOUT(16)) dut_rl (
    .clk(clk), .rst(rst), .kif(kif1.slave));

  typedef struct packed {
    logic [11:0] key;
    logic        loaded;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        err;
    logic        loaded;
    logic [11:0] key;
  } obs_t;

  int total = 0;
  int bad   = 0;

  resp_t exp_q0[$];
  resp_t exp_q1[$];

  logic [11:0] m_key    [2];
  bit          m_loaded [2];
  bit          m_err    [2];
  bit          m_locked [2];
  bit          busy_prev[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t obs(input int idx);
    obs_t o;
    if (idx == 0) o = '{kif0.busy, kif0.key_ready, kif0.key_err, kif0.key_loaded, kif0.key_out};
    else          o = '{kif1.busy, kif1.key_ready, kif1.key_err, kif1.key_loaded, kif1.key_out};
    return o;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_key[i]    = 12'h000;
      m_loaded[i] = 1'b0;
      m_err[i]    = 1'b0;
      m_locked[i] = 1'b0;
    end
  endfunction

  // Frame outcome from the rules: locked ignores, timeout/parity error keeps the key, good frame commits.
  function automatic void model_frame(input int idx, input logic [11:0] k, input logic p, input bit timeout);
    resp_t r;
    if (m_locked[idx]) return;
    if (timeout) m_err[idx] = 1'b1;
    else if ((^k ^ p) == 1'b0) begin
      m_key[idx]    = k;
      m_loaded[idx] = 1'b1;
      m_err[idx]    = 1'b0;
      m_locked[idx] = (idx == 0);
    end else m_err[idx] = 1'b1;
    r.key = m_key[idx]; r.loaded = m_loaded[idx]; r.err = m_err[idx];
    if (idx == 0) exp_q0.push_back(r);
    else          exp_q1.push_back(r);
  endfunction

  task automatic mon(input int idx);
    obs_t  o;
    resp_t act, e;
    o = obs(idx);
    act.key = o.key; act.loaded = o.loaded; act.err = o.err;
    if (busy_prev[idx] && !o.busy) begin
      if ((idx == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        total++; bad++;
        $display("FAIL sb%0d_unexpected: got frame end %0h expected none", idx, act);
      end else begin
        e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("sb%0d_resp", idx), 32'(act), 32'(e));
      end
    end
    busy_prev[idx] = o.busy;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_prev[0] = 1'b0;
      busy_prev[1] = 1'b0;
    end else begin
      mon(0);
      mon(1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cyc(); cyc();
    chk("sb0_drain", exp_q0.size(), 0);
    chk("sb1_drain", exp_q1.size(), 0);
  endtask

  task automatic full_reset();
    rst = 1'b1;
    model_reset();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic frame(input logic [11:0] k, input logic p, input bit stall, input int nbeats);
    logic [11:0] old_key[2];
    bit          active [2];
    obs_t        o;
    int          g;
    if (stall) begin
      kif0.key_valid = 1'b1; kif0.key_bit = 1'($urandom);
      cyc();
      kif0.key_valid = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      old_key[i] = m_key[i];
      active[i]  = !m_locked[i];
      model_frame(i, k, p, nbeats < 13);
    end
    kif0.load_start = 1'b1;
    cyc();
    kif0.load_start = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (stall) begin
        g = $urandom_range(0, 3);
        kif0.key_valid = 1'b0;
        repeat (g) begin
          kif0.load_start = 1'($urandom);
          cyc();
        end
        kif0.load_start = 1'b0;
      end
      kif0.key_valid = 1'b1;
      kif0.key_bit   = (b < 12) ? k[b] : p;
      if (b == 0) begin
        for (int i = 0; i < 2; i++) begin
          o = obs(i);
          chk($sformatf("ready_shift%0d", i), o.ready, active[i]);
          chk($sformatf("err_shift%0d", i), o.err, active[i] ? 1'b0 : m_err[i]);
        end
      end
      cyc();
    end
    if (nbeats == 13) begin
      kif0.key_valid = stall; kif0.key_bit = 1'($urandom);
      for (int i = 0; i < 2; i++) begin
        o = obs(i);
        chk($sformatf("no_early%0d", i), o.key, old_key[i]);
        chk($sformatf("ready_check%0d", i), o.ready, 1'b0);
        chk($sformatf("busy_check%0d", i), o.busy, active[i]);
      end
      cyc();
      kif0.key_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        o = obs(i);
        chk($sformatf("commit_key%0d", i), o.key, m_key[i]);
        chk($sformatf("commit_loaded%0d", i), o.loaded, m_loaded[i]);
        chk($sformatf("commit_busy%0d", i), o.busy, 1'b0);
      end
    end else begin
      kif0.key_valid = 1'b0;
      repeat (15) cyc();
      for (int i = 0; i < 2; i++) begin
        o = obs(i);
        chk($sformatf("to_busy15_%0d", i), o.busy, active[i]);
        chk($sformatf("to_err15_%0d", i), o.err, active[i] ? 1'b0 : m_err[i]);
      end
      cyc();
      for (int i = 0; i < 2; i++) begin
        o = obs(i);
        chk($sformatf("to_err16_%0d", i), o.err, m_err[i]);
        chk($sformatf("to_ready16_%0d", i), o.ready, 1'b0);
        chk($sformatf("to_key16_%0d", i), o.key, m_key[i]);
      end
    end
    drain();
  endtask

  task automatic mid_reset(input logic [11:0] k, input int nbeats);
    obs_t o;
    kif0.load_start = 1'b1;
    cyc();
    kif0.load_start = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      kif0.key_valid = 1'b1; kif0.key_bit = k[b];
      cyc();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      o = obs(i);
      chk($sformatf("mid_rst_key%0d", i), o.key, 12'h000);
      chk($sformatf("mid_rst_loaded%0d", i), o.loaded, 1'b0);
      chk($sformatf("mid_rst_busy%0d", i), o.busy, 1'b0);
      chk($sformatf("mid_rst_ready%0d", i), o.ready, 1'b0);
    end
    kif0.key_valid = 1'b0;
    cyc();
    rst = 1'b0;
    drain();
  endtask

  initial begin
    obs_t o;
    rst = 1'b1;
    kif0.load_start = 1'b0;
    kif0.key_bit    = 1'b0;
    kif0.key_valid  = 1'b0;
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      o = obs(i);
      chk($sformatf("rst_key%0d", i), o.key, 12'h000);
      chk($sformatf("rst_loaded%0d", i), o.loaded, 1'b0);
      chk($sformatf("rst_err%0d", i), o.err, 1'b0);
      chk($sformatf("rst_ready%0d", i), o.ready, 1'b0);
      chk($sformatf("rst_busy%0d", i), o.busy, 1'b0);
    end

    frame(12'hA5C, 1'b1, 1'b0, 13);
    frame(12'h5A5, 1'b0, 1'b0, 5);
    frame(12'h3F0, 1'b0, 1'b0, 13);

    full_reset();
    frame(12'hA5C, 1'b0, 1'b1, 13);
    frame(12'h001, 1'b1, 1'b0, 13);

    mid_reset(12'hA5C, 7);
    frame(12'hA5C, 1'b0, 1'b0, 13);

    for (int n = 0; n < 24; n++) begin
      int          r;
      logic [11:0] k;
      logic        flip;
      r    = $urandom_range(0, 9);
      k    = 12'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      if (r == 0)      mid_reset(k, $urandom_range(0, 12));
      else if (r == 1) frame(k, 1'b0, 1'($urandom), $urandom_range(0, 12));
      else if (r == 2) full_reset();
      else             frame(k, (^k) ^ flip, 1'($urandom), 13);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
